regfile_multiport: RTL

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_clear_fsm.sv | 69 ++++++
 rtl/regfile_multiport.sv | 100 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file and its bulk-clear sequencer.
package regfile_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StDone  = 2'd2
  } clear_state_e;

  function automatic int unsigned addr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: sweeps every register address once, then pulses done for one cycle.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear_req,
  output logic [AW-1:0] o_sweep_addr,
  output logic          o_sweep_en,
  output logic          o_busy,
  output logic          o_done
);

  clear_state_e  r_state;
  logic [AW-1:0] r_cnt;
  logic          r_sweep_en;
  logic          r_busy;
  logic          r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_sweep_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_clear_req) begin
            r_state    <= StClear;
            r_cnt      <= '0;
            r_sweep_en <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        StClear: begin
          r_cnt <= r_cnt + AW'(1);
          // Last address zeroed this cycle; the counter wraps back to 0 on the way out.
          if (r_cnt == AW'(DEPTH - 1)) begin
            r_state    <= StDone;
            r_sweep_en <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state    <= StIdle;
          r_sweep_en <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign o_sweep_addr = r_cnt;
  assign o_sweep_en   = r_sweep_en;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: rtl/regfile_multiport.sv
// Multi-read, single-write register file with optional zero register, write forwarding,
// a sequenced bulk clear and a registered debug read port.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_READ = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = addr_width(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      we,
  input  logic [AW-1:0]             waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [NUM_READ*AW-1:0]    rd_addr,
  output logic [NUM_READ*WIDTH-1:0] rd_data,
  input  logic                      clear_req,
  output logic                      clear_busy,
  output logic                      clear_done,
  input  logic                      dbg_req,
  input  logic [AW-1:0]             dbg_addr,
  output logic [WIDTH-1:0]          dbg_data,
  output logic                      dbg_valid
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_dbg_data;
  logic             r_dbg_valid;

  logic [AW-1:0]    w_sweep_addr;
  logic             w_sweep_en;
  logic             w_busy;
  logic             w_done;
  logic             w_wr_act;

  regfile_clear_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_fsm (
    .clk          (clk),
    .rst_n        (reset_n),
    .i_clear_req  (clear_req),
    .o_sweep_addr (w_sweep_addr),
    .o_sweep_en   (w_sweep_en),
    .o_busy       (w_busy),
    .o_done       (w_done)
  );

  // User writes (and forwarding) are only live while the sweep is idle.
  assign w_wr_act = we & ~w_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_sweep_en && (w_sweep_addr == AW'(i))) begin
          r_mem[i] <= '0;
        end else if (w_wr_act && (waddr == AW'(i)) && !(ZERO_REG && (i == 0))) begin
          r_mem[i] <= wdata;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_zero;
    logic          w_fwd;

    assign w_ra   = rd_addr[k*AW +: AW];
    assign w_zero = ZERO_REG && (w_ra == '0);
    assign w_fwd  = BYPASS && w_wr_act && (waddr == w_ra);
    assign rd_data[k*WIDTH +: WIDTH] = w_zero ? '0 : (w_fwd ? wdata : r_mem[w_ra]);
  end

  // Debug reads see the stored array only, never the in-flight write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dbg_valid <= 1'b0;
      r_dbg_data  <= '0;
    end else begin
      r_dbg_valid <= dbg_req;
      if (dbg_req) begin
        r_dbg_data <= r_mem[dbg_addr];
      end
    end
  end

  assign clear_busy = w_busy;
  assign clear_done = w_done;
  assign dbg_data   = r_dbg_data;
  assign dbg_valid  = r_dbg_valid;

endmodule
